// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU writeback vs. queued LSU load returns.
// Latency: a granted write appears on rf_we/rf_rd/rf_wd one clk edge later; a pushed load is grantable from the next cycle.
// Backpressure: alu_ready drops when the LSU is forced (starvation or same-rd conflict); lsu_ready = !full.
// Optional build macro WB_STATS_EN adds saturating stall / LSU-write counters.
module regfile_wb_arbiter #(
  parameter int LSU_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [2:0]  alu_rd,
  input  logic [15:0] alu_wd,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [2:0]  lsu_rd,
  input  logic [15:0] lsu_wd,
  output logic        lsu_ready,
  output logic        rf_we,
  output logic [2:0]  rf_rd,
  output logic [15:0] rf_wd
`ifdef WB_STATS_EN
  ,
  output logic [15:0] stat_alu_stall,
  output logic [15:0] stat_lsu_wr
`endif
);

  localparam int AW = $clog2(LSU_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [2:0]    fifo_rd [LSU_DEPTH];
  logic [15:0]   fifo_wd [LSU_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] head;
  logic          empty;
  logic          full;
  logic          push;
  logic          conf_hit;
  logic          conf;
  logic          force_lsu;
  logic          grant_lsu;
  logic          grant_alu;
  logic [SW-1:0] starve_cnt;

  // Occupancy from the extra-bit pointers; equal low bits with differing MSB means full.
  always_comb begin
    count = wr_ptr - rd_ptr;
    head  = rd_ptr[AW-1:0];
    empty = (count == '0);
    full  = (count == (AW+1)'(LSU_DEPTH));
  end

  // Look for an older queued load to the same register as the incoming ALU write.
  always_comb begin
    conf_hit = 1'b0;
    for (int i = 0; i < LSU_DEPTH; i++) begin
      // Slot i is live when its distance from the head is below the occupancy.
      if (({1'b0, AW'(i) - head} < count) && (fifo_rd[i] == alu_rd)) begin
        conf_hit = 1'b1;
      end
    end
    conf = alu_valid && (alu_rd != 3'd0) && conf_hit;
  end

  // Grant selection: forced LSU first, then ALU, then LSU on otherwise idle cycles.
  always_comb begin
    force_lsu = !empty && ((starve_cnt == SW'(STARVE_LIMIT)) || conf);
    grant_lsu = force_lsu || (!alu_valid && !empty);
    grant_alu = !force_lsu && alu_valid;
    alu_ready = !force_lsu;
    lsu_ready = !full;
    push      = lsu_valid && !full;
  end

  // FIFO pointer update; pop happens whenever the head is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + (AW+1)'(1);
      if (grant_lsu) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO payload storage; contents are meaningless outside the live window so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr[AW-1:0]] <= lsu_rd;
      fifo_wd[wr_ptr[AW-1:0]] <= lsu_wd;
    end
  end

  // Registered write port; r0 writes are consumed but never enabled, idle holds address/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_rd <= 3'd0;
      rf_wd <= 16'd0;
    end else if (grant_lsu) begin
      rf_we <= (fifo_rd[head] != 3'd0);
      rf_rd <= fifo_rd[head];
      rf_wd <= fifo_wd[head];
    end else if (grant_alu) begin
      rf_we <= (alu_rd != 3'd0);
      rf_rd <= alu_rd;
      rf_wd <= alu_wd;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Starvation counter: counts ALU wins while loads wait, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (empty || grant_lsu) begin
      starve_cnt <= '0;
    end else if (grant_alu && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

`ifdef WB_STATS_EN
  // Saturating statistics: ALU stall cycles and LSU grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_alu_stall <= 16'd0;
      stat_lsu_wr    <= 16'd0;
    end else begin
      if (alu_valid && !alu_ready && (stat_alu_stall != 16'hFFFF))
        stat_alu_stall <= stat_alu_stall + 16'd1;
      if (grant_lsu && (stat_lsu_wr != 16'hFFFF))
        stat_lsu_wr <= stat_lsu_wr + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic.
// A queue-based reference model predicts readies and each cycle's registered write;
// a monitor process pops the predicted write one edge later and compares.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [15:0] alu_wd;
  logic        alu_ready;
  logic        lsu_valid;
  logic [2:0]  lsu_rd;
  logic [15:0] lsu_wd;
  logic        lsu_ready;
  logic        rf_we;
  logic [2:0]  rf_rd;
  logic [15:0] rf_wd;
`ifdef WB_STATS_EN
  logic [15:0] stat_alu_stall;
  logic [15:0] stat_lsu_wr;
`endif

  regfile_wb_arbiter #(.LSU_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
`ifdef WB_STATS_EN
    , .stat_alu_stall(stat_alu_stall), .stat_lsu_wr(stat_lsu_wr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [2:0] rd; logic [15:0] wd; } rfexp_t;
  typedef struct packed { logic [2:0] rd; logic [15:0] wd; } ld_t;

  rfexp_t      sb[$];
  ld_t         pend[$];
  int          starve;
  logic [2:0]  last_rd;
  logic [15:0] last_wd;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    pend.delete();
    starve  = 0;
    last_rd = 3'd0;
    last_wd = 16'd0;
  endtask

  // One cycle: drive at negedge, check readies against the model, predict the write.
  task automatic step(input logic av, input logic [2:0] ard, input logic [15:0] awd,
                      input logic lv, input logic [2:0] lrd, input logic [15:0] lwd,
                      output logic alu_acc);
    logic   conf, frc, full, wr;
    ld_t    w;
    rfexp_t e;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_wd = awd;
    lsu_valid = lv; lsu_rd = lrd; lsu_wd = lwd;
    #1;
    full = (pend.size() == DEPTH);
    conf = 1'b0;
    if (av && ard != 3'd0)
      foreach (pend[i]) if (pend[i].rd == ard) conf = 1'b1;
    frc = (pend.size() > 0) && ((starve == LIMIT) || conf);
    chk("alu_ready", alu_ready, !frc);
    chk("lsu_ready", lsu_ready, !full);
    wr = 1'b1;
    w  = '0;
    if (frc || (!av && pend.size() > 0)) begin
      w = pend.pop_front();
      starve = 0;
    end else if (av) begin
      w = '{rd: ard, wd: awd};
      starve = (pend.size() > 0) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
    end else begin
      wr = 1'b0;
      starve = 0;
    end
    if (wr) begin
      last_rd = w.rd;
      last_wd = w.wd;
    end
    e = '{we: wr && (w.rd != 3'd0), rd: last_rd, wd: last_wd};
    sb.push_back(e);
    if (lv && !full) pend.push_back('{rd: lrd, wd: lwd});
    alu_acc = av && !frc;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, a);
  endtask

  // Keep an ALU request up until it is accepted (pipeline-stall semantics).
  task automatic alu_hold(input logic [2:0] rd, input logic [15:0] wd);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 20) begin
      step(1'b1, rd, wd, 1'b0, 3'd0, 16'd0, a);
      n++;
    end
    if (!a) chk("alu_accept_timeout", 0, 1);
  endtask

  // Monitor: one registered write is predicted per driven cycle; compare after the edge.
  initial begin
    rfexp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rf_we", rf_we, e.we);
        chk("rf_rd", rf_rd, e.rd);
        chk("rf_wd", rf_wd, e.wd);
      end
    end
  end

  initial begin
    logic a;
    logic hold_v;
    logic [2:0] hold_rd;
    logic [15:0] hold_wd;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = 3'd0; alu_wd = 16'd0;
    lsu_valid = 1'b0; lsu_rd = 3'd0; lsu_wd = 16'd0;
    model_reset();
    #3;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_rd", rf_rd, 0);
    chk("reset_rf_wd", rf_wd, 0);
    chk("reset_alu_ready", alu_ready, 1);
    chk("reset_lsu_ready", lsu_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU alone
    step(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'd0, a);
    idle(1);
    // LSU alone
    step(1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 16'hBEEF, a);
    idle(2);
    // Starvation: one load waits behind a stream of ALU writes
    step(1'b0, 3'd0, 16'd0, 1'b1, 3'd2, 16'h2222, a);
    for (int i = 0; i < 7; i++) alu_hold(3'd4, 16'h4000 + 16'(i));
    idle(1);
    // Same-destination conflict: load must land before the younger ALU write
    step(1'b0, 3'd0, 16'd0, 1'b1, 3'd6, 16'hAAAA, a);
    alu_hold(3'd6, 16'h5555);
    idle(1);
    // Full FIFO while ALU is busy, then r0 load and r0 ALU
    step(1'b1, 3'd1, 16'h0101, 1'b1, 3'd7, 16'h7777, a);
    step(1'b1, 3'd1, 16'h0102, 1'b1, 3'd0, 16'hDEAD, a);
    step(1'b1, 3'd1, 16'h0103, 1'b1, 3'd3, 16'h3333, a);
    idle(3);
    step(1'b1, 3'd0, 16'hF00D, 1'b0, 3'd0, 16'd0, a);
    idle(1);
    // Reset mid-operation with two queued loads
    step(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2002, a);
    step(1'b1, 3'd1, 16'h1112, 1'b1, 3'd3, 16'h3003, a);
    #2;
    rst_n = 1'b0;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    model_reset();
    #1;
    chk("midreset_rf_we", rf_we, 0);
    chk("midreset_lsu_ready", lsu_ready, 1);
    chk("midreset_alu_ready", alu_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_release_rf_we", rf_we, 0);
    idle(4);

    // Random traffic; ALU requests persist until accepted
    hold_v = 1'b0; hold_rd = 3'd0; hold_wd = 16'd0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold_v) begin
        hold_v  = ($urandom_range(0, 9) < 6);
        hold_rd = 3'($urandom_range(0, 7));
        hold_wd = 16'($urandom);
      end
      step(hold_v, hold_rd, hold_wd,
           ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), 16'($urandom), a);
      if (a) hold_v = 1'b0;
    end
    idle(4);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between the in-order ALU writeback stage and the out-of-band LSU load-return path. ALU writebacks have priority. Load returns queue in a small FIFO and drain on free cycles. A starvation limit and a same-destination ordering check guarantee forward progress and correct write order. Sits between the WB stage / LSU and the 8x16 register file (r0 hard-wired zero).

Parameters:
LSU_DEPTH, 2, load-return FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may wait before the LSU is forced a grant (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
alu_valid  in  1  ALU writeback request
alu_rd  in  3  ALU destination register
alu_wd  in  16  ALU write data
alu_ready  out  1  ALU request accepted this cycle; pipeline stalls when 0 with alu_valid=1
lsu_valid  in  1  load-return request
lsu_rd  in  3  load destination register
lsu_wd  in  16  load data
lsu_ready  out  1  FIFO can accept (=!full)
rf_we  out  1  regfile write enable (registered)
rf_rd  out  3  regfile write address (registered)
rf_wd  out  16  regfile write data (registered)

Behaviour:
- Reset (async, rst_n=0): FIFO empty, starve counter 0, rf_we=0, rf_rd=0, rf_wd=0. Resulting combinational outputs: lsu_ready=1, alu_ready=1.
- Reset mid-operation discards queued loads and any pending write; no rf_we pulse in the cycle after release.
- FIFO push: lsu_valid & lsu_ready.
- lsu_ready = !full, with no bypass. A push and pop in the same cycle on a full FIFO is not allowed: ready=0 that cycle.
- A pushed entry is eligible for grant from the next cycle (no same-cycle pass-through).
- Conflict, evaluated each cycle: conf = alu_valid & alu_rd!=0 & alu_rd equals rd of any valid FIFO entry.
- force = FIFO non-empty & (starve_cnt==STARVE_LIMIT | conf).
- Grant priority, one grant per cycle:
  1) force -> grant LSU head; alu_ready=0.
  2) else alu_valid -> grant ALU; alu_ready=1.
  3) else FIFO non-empty -> grant LSU head.
  4) else idle.
- alu_ready = !force (combinational). It may be 1 while alu_valid=0.
- Granted write registers onto rf_we/rf_rd/rf_wd at the next clk edge: one-cycle latency.
- A granted write with rd==0 is consumed (popped or accepted) but produces rf_we=0. rf_rd/rf_wd still update.
- Idle cycle: rf_we=0; rf_rd and rf_wd hold their previous values.
- starve_cnt:
  - Cleared when the FIFO is empty or the LSU is granted.
  - Otherwise increments each cycle the FIFO is non-empty and the ALU is granted.
  - Saturates at STARVE_LIMIT.
- FIFO pointers wrap modulo LSU_DEPTH; full/empty are distinguished by an extra pointer bit.
- Ordering guarantee: for any rd, the final regfile value equals the later-accepted write. The conf rule drains older queued loads before a younger ALU write to the same register.

Optional Feature:
WB_STATS_EN
- Defined:
  - Adds output stat_alu_stall[15:0]: counts cycles with alu_valid=1 & alu_ready=0.
  - Adds output stat_lsu_wr[15:0]: counts LSU grants.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
1) ALU alone: alu_valid=1, rd=3, wd=16'h1234 at cycle N -> rf_we=1, rf_rd=3, rf_wd=16'h1234 at N+1; alu_ready stays 1.
2) LSU alone: push rd=5, wd=16'hBEEF at N with ALU idle -> rf_we=1, rf_rd=5, rf_wd=16'hBEEF at N+2; lsu_ready=1 throughout.
3) Starvation: push one load rd=2, then continuous ALU writes to rd=4 -> after 4 ALU grants, alu_ready=0 for one cycle and the load write rd=2 appears on the next edge; ALU resumes.
4) Ordering conflict: queue load rd=6, wd=16'hAAAA, then ALU rd=6, wd=16'h5555 the next cycle -> alu_ready=0 until the load drains; rf writes in order AAAA then 5555.
5) Full/r0: 2 pushes with ALU busy -> lsu_ready=0 with count=2. A load to rd=0 is popped with rf_we=0. ALU rd=0 produces rf_we=0 with alu_ready=1.
6) Reset mid-operation: FIFO holds 2 entries, assert rst_n=0 asynchronously -> rf_we=0 immediately, lsu_ready=1. No queued write appears after release.
